// File: rtl/node_pkg.sv
// node_pkg: shared definitions for the DS-link echo node.
//   - control codes, written as {c0,c1} in transmission order
//   - character lengths in bits, including P and F
//   - receiver state enum
//   - ctrl_char(): builds a 4-bit control character, bit 0 sent first
package node_pkg;

  localparam logic [1:0] CODE_FCT   = 2'b00;
  localparam logic [1:0] CODE_EOP_1 = 2'b01;
  localparam logic [1:0] CODE_EOP_2 = 2'b10;
  localparam logic [1:0] CODE_ESC   = 2'b11;

  localparam int CTRL_LEN = 4;
  localparam int DATA_LEN = 10;

  typedef enum logic {RX_HUNT, RX_SYNC} rx_state_t;

  // Control character as a shift vector: [0]=P, [1]=F=1, [2]=c0, [3]=c1.
  function automatic logic [3:0] ctrl_char(input logic [1:0] code, input logic p);
    return {code[0], code[1], 1'b1, p};
  endfunction

endpackage

// File: rtl/ds_rx.sv
// ds_rx: DS-link receiver.
//   clk_pad/rst       : clock, synchronous active-high reset
//   d_in/s_in         : asynchronous DS-link data and strobe
//   push/data         : one-cycle strobe with a received data byte
//   perr              : one-cycle pulse on a parity mismatch
//   link_active       : set on the first NULL, cleared on an idle timeout
module ds_rx
  import node_pkg::*;
#(
  parameter int DISC_TIMEOUT = 64
) (
  input  logic       clk_pad,
  input  logic       rst,
  input  logic       d_in,
  input  logic       s_in,
  output logic       push,
  output logic [7:0] data,
  output logic       perr,
  output logic       link_active
);
  localparam int TW = $clog2(DISC_TIMEOUT + 1);

  logic [1:0]    d_sync, s_sync;   // [1] is the synchronised value
  logic          x_q;              // last seen d^s
  logic          bit_evt, bit_val;
  logic [6:0]    win;              // hunt window including the new bit, [6] oldest
  logic          null_hit, par_bad, timeout;
  rx_state_t     state, state_nx;
  logic [5:0]    hunt_sh;
  logic [3:0]    bit_idx;          // position inside the current character
  logic          p_q, is_ctrl, par_prev, par_acc;
  logic [6:0]    sh;               // data bits arrive LSB first
  logic [TW-1:0] idle_cnt;

  assign bit_val  = d_sync[1];
  assign bit_evt  = (d_sync[1] ^ s_sync[1]) != x_q;
  assign win      = {hunt_sh, bit_val};
  // ESC F,c0,c1 = 111, FCT P = don't care, FCT F,c0,c1 = 100
  assign null_hit = bit_evt && (state == RX_HUNT) && (win[6:4] == 3'b111) && (win[2:0] == 3'b100);
  assign par_bad  = bit_evt && (state == RX_SYNC) && (bit_idx == 4'd1) && !(par_prev ^ p_q ^ bit_val);
  assign timeout  = !bit_evt && (idle_cnt == TW'(DISC_TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    if (timeout || par_bad) state_nx = RX_HUNT;
    else if (null_hit)      state_nx = RX_SYNC;
  end

  always_ff @(posedge clk_pad) begin
    if (rst) begin
      d_sync      <= '0;
      s_sync      <= '0;
      x_q         <= 1'b0;
      state       <= RX_HUNT;
      hunt_sh     <= '0;
      bit_idx     <= '0;
      p_q         <= 1'b0;
      is_ctrl     <= 1'b0;
      par_prev    <= 1'b0;
      par_acc     <= 1'b0;
      sh          <= '0;
      idle_cnt    <= '0;
      push        <= 1'b0;
      data        <= '0;
      perr        <= 1'b0;
      link_active <= 1'b0;
    end else begin
      d_sync <= {d_sync[0], d_in};
      s_sync <= {s_sync[0], s_in};
      state  <= state_nx;
      push   <= 1'b0;
      perr   <= par_bad;

      if (bit_evt) begin
        x_q      <= ~x_q;
        idle_cnt <= '0;
      end else if (idle_cnt != TW'(DISC_TIMEOUT)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (timeout)       link_active <= 1'b0;
      else if (null_hit) link_active <= 1'b1;

      if (timeout || par_bad) begin
        // clear the window so stale bits cannot fake a NULL
        hunt_sh <= '0;
        bit_idx <= '0;
      end else if (bit_evt) begin
        if (state == RX_HUNT) begin
          // the FCT that completes a match has c0^c1 = 0, so parity history restarts at 0
          hunt_sh  <= win[5:0];
          bit_idx  <= '0;
          par_prev <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 4'd0) begin
            p_q <= bit_val;
          end else if (bit_idx == 4'd1) begin
            is_ctrl <= bit_val;
            par_acc <= 1'b0;
          end else begin
            sh      <= {bit_val, sh[6:1]};
            par_acc <= par_acc ^ bit_val;
            if ((is_ctrl && bit_idx == 4'(CTRL_LEN - 1)) || bit_idx == 4'(DATA_LEN - 1)) begin
              bit_idx  <= '0;
              par_prev <= par_acc ^ bit_val;
              if (!is_ctrl) begin
                push <= 1'b1;
                data <= {bit_val, sh};
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/node.sv
// node: DS-link echo node. Received data bytes are queued and retransmitted;
// NULLs fill the line when nothing is queued.
//   clk_pad/rst : clock, synchronous active-high reset
//   d_in/s_in   : incoming DS link (asynchronous)
//   d_out/s_out : outgoing DS link (registered)
//   sw[0]       : LED nibble select; btn[0] clears sticky flags
//   led         : nibble of the last received byte
//   ledb        : {overflow, fifo_full, parity_err, link_active}
module node
  import node_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int DISC_TIMEOUT = 64
) (
  input  logic       clk_pad,
  input  logic       rst,
  input  logic       d_in,
  input  logic       s_in,
  output logic       d_out,
  output logic       s_out,
  input  logic [3:0] sw,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic [3:0] ledb
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic       rx_push, rx_perr, link_active;
  logic [7:0] rx_data;

  ds_rx #(.DISC_TIMEOUT(DISC_TIMEOUT)) u_rx (
    .clk_pad     (clk_pad),
    .rst         (rst),
    .d_in        (d_in),
    .s_in        (s_in),
    .push        (rx_push),
    .data        (rx_data),
    .perr        (rx_perr),
    .link_active (link_active)
  );

  // ---------------- echo FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, wr_en, drop;
  logic [7:0]    rd_byte;

  assign full    = count == (AW + 1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign rd_byte = mem[rd_ptr];
  // a pop in the same cycle frees a slot, so push+pop on a full FIFO is accepted
  assign wr_en   = rx_push && (!full || pop);
  assign drop    = rx_push && full && !pop;

  always_ff @(posedge clk_pad) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk_pad) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic [DW-1:0] div_cnt;
  logic [3:0]    bits_left;
  logic [9:0]    tx_sh;
  logic          tx_par;        // XOR of the previous character's data/control bits
  logic          bit_tick, load, tx_bit;
  logic [9:0]    next_char;
  logic [3:0]    next_len;
  logic          next_par;

  assign bit_tick = div_cnt == '0;
  assign load     = bit_tick && (bits_left == '0);
  assign pop      = load && !empty;
  assign tx_bit   = load ? next_char[0] : tx_sh[0];

  // P is chosen so prev ^ P ^ F = 1. NULL goes out as one 8-bit unit: the ESC's
  // P is tx_par, and the FCT's P is always 0 because ESC's c0^c1 is 0.
  always_comb begin
    next_char = {2'b00, ctrl_char(CODE_FCT, 1'b0), ctrl_char(CODE_ESC, tx_par)};
    next_len  = 4'(2 * CTRL_LEN);
    next_par  = 1'b0;
    if (!empty) begin
      next_char = {rd_byte, 1'b0, ~tx_par};
      next_len  = 4'(DATA_LEN);
      next_par  = ^rd_byte;
    end
  end

  always_ff @(posedge clk_pad) begin
    if (rst) begin
      d_out     <= 1'b0;
      s_out     <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
    end else if (bit_tick) begin
      div_cnt <= DW'(CLK_DIV - 1);
      d_out   <= tx_bit;
      if (tx_bit == d_out) s_out <= ~s_out;
      if (load) begin
        tx_sh     <= next_char >> 1;
        bits_left <= next_len - 1'b1;
        tx_par    <= next_par;
      end else begin
        tx_sh     <= tx_sh >> 1;
        bits_left <= bits_left - 1'b1;
      end
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // ---------------- status / LEDs ----------------
  logic       parity_err, overflow;
  logic [7:0] last_rx;
  logic       unused_in;

  assign unused_in = ^{sw[3:1], btn[3:1]};

  always_ff @(posedge clk_pad) begin
    if (rst) begin
      parity_err <= 1'b0;
      overflow   <= 1'b0;
      last_rx    <= '0;
    end else begin
      if (rx_perr)     parity_err <= 1'b1;
      else if (btn[0]) parity_err <= 1'b0;
      if (drop)        overflow   <= 1'b1;
      else if (btn[0]) overflow   <= 1'b0;
      if (rx_push)     last_rx    <= rx_data;
    end
  end

  assign led  = sw[0] ? last_rx[7:4] : last_rx[3:0];
  assign ledb = {overflow, full, parity_err, link_active};

endmodule

// File: tb/tb_node.sv
// tb_node: drives DS-link characters into node, decodes its DS output stream,
// and compares echoed bytes against a queue of expected bytes.
module tb_node;
  localparam int CLK_DIV = 4;

  logic       clk_pad, rst, d_in, s_in, d_out, s_out;
  logic [3:0] sw, btn, led, ledb;

  node dut (
    .clk_pad (clk_pad),
    .rst     (rst),
    .d_in    (d_in),
    .s_in    (s_in),
    .d_out   (d_out),
    .s_out   (s_out),
    .sw      (sw),
    .btn     (btn),
    .led     (led),
    .ledb    (ledb)
  );

  initial begin
    clk_pad = 1'b0;
    forever #5 clk_pad = ~clk_pad;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic       echo_on = 1'b1;
  logic       seen_full = 1'b0;
  int         bitcyc = 4;
  logic       tb_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk_pad);
    #1;
  endtask

  // ---------------- stimulus: DS encoder ----------------
  task automatic send_bit(input logic b);
    if (b == d_in) s_in = ~s_in;
    d_in = b;
    repeat (bitcyc) @(posedge clk_pad);
    #1;
  endtask

  // code given as {c0,c1}
  task automatic send_ctrl(input logic [1:0] code);
    send_bit(tb_prev);           // P = ~(prev ^ F) with F = 1
    send_bit(1'b1);
    send_bit(code[1]);
    send_bit(code[0]);
    tb_prev = code[1] ^ code[0];
  endtask

  task automatic send_null();
    send_ctrl(2'b11);
    send_ctrl(2'b00);
  endtask

  task automatic send_data(input logic [7:0] b, input logic bad, input logic track);
    if (track) exp_q.push_back(b);
    send_bit(~tb_prev ^ bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    tb_prev = ^b;
  endtask

  // ---------------- monitor: DS decoder + scoreboard ----------------
  initial begin
    logic       px, prv, want_fct, started;
    int         gap, nb;
    logic [9:0] ch;
    logic [7:0] b, e;
    px = 0; prv = 0; want_fct = 0; started = 0; gap = 0; nb = 0; ch = '0;
    forever begin
      @(negedge clk_pad);
      if (ledb[2]) seen_full = 1'b1;
      if (rst) begin
        px = 0; prv = 0; want_fct = 0; started = 0; gap = 0; nb = 0;
      end else begin
        gap++;
        if ((d_out ^ s_out) != px) begin
          px = d_out ^ s_out;
          if (started) chk("bit_period", gap, CLK_DIV);
          started = 1; gap = 0;
          ch[nb] = d_out;
          nb++;
          if (nb == 4 && ch[1]) begin
            chk("ctrl_parity", prv ^ ch[0] ^ ch[1], 1);
            if (want_fct) chk("null_fct_code", {ch[2], ch[3]}, 2'b00);
            else          chk("null_esc_code", {ch[2], ch[3]}, 2'b11);
            want_fct = ~want_fct;
            prv = ch[2] ^ ch[3];
            nb = 0;
          end else if (nb == 10) begin
            chk("data_parity", prv ^ ch[0] ^ ch[1], 1);
            chk("data_after_esc", want_fct, 0);
            b = ch[9:2];
            prv = ^b;
            nb = 0;
            if (echo_on) begin
              chk("echo_pending", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("echo_byte", b, e);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] r;
    rst = 1; d_in = 0; s_in = 0; sw = 0; btn = 0;
    repeat (3) @(posedge clk_pad);
    @(negedge clk_pad);
    chk("rst_d_out", d_out, 0);
    chk("rst_s_out", s_out, 0);
    chk("rst_led", led, 0);
    chk("rst_ledb", ledb, 0);

    @(posedge clk_pad); #1 rst = 0;
    @(negedge clk_pad); chk("pre_first_bit", {d_out, s_out}, 2'b00);
    @(negedge clk_pad); chk("first_bit", {d_out, s_out}, 2'b01);
    repeat (40) align();
    chk("idle_ledb", ledb, 0);

    // sync, then data including bytes that look like NULL fragments
    repeat (3) send_null();
    @(negedge clk_pad); chk("link_up", ledb[0], 1);
    align();
    send_data(8'hE6, 0, 1);
    send_data(8'h2E, 0, 1);
    send_data(8'h2E, 0, 1);
    send_data(8'h3E, 0, 1);
    send_data(8'h3E, 0, 1);
    send_null();

    // back-to-back random bursts
    for (int i = 0; i < 16; i++) begin r = 8'($urandom_range(0, 255)); send_data(r, 0, 1); end
    for (int i = 0; i < 64; i++) begin r = 8'($urandom_range(0, 255)); send_data(r, 0, 1); end
    send_null();
    @(negedge clk_pad);
    chk("no_overflow", ledb[3], 0);
    chk("link_still_up", ledb[0], 1);
    align();

    // corrupted parity: dropped, then resync on NULL
    send_data(8'h00, 1, 0);
    send_null();
    send_null();
    @(negedge clk_pad); chk("parity_err_set", ledb[1], 1);
    align();
    send_data(8'h5A, 0, 1);
    send_null();
    btn = 4'b0001; align(); btn = 4'b0000;
    @(negedge clk_pad); chk("parity_err_clr", ledb[1], 0);
    align();

    // last byte 0xA5, then static line
    send_null();
    send_data(8'hA5, 0, 1);
    repeat (100) align();
    chk("link_timeout", ledb[0], 0);
    chk("led_lo", led, 4'b0101);
    sw = 4'b0001; #1;
    chk("led_hi", led, 4'b1010);
    sw = 4'b0000;

    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) align();
    chk("drain", exp_q.size(), 0);
    repeat (100) align();
    echo_on = 1'b0;

    // overflow: input faster than the echo rate
    seen_full = 1'b0;
    send_null();
    send_null();
    bitcyc = 3;
    for (int i = 0; i < 80; i++) begin r = 8'($urandom_range(0, 255)); send_data(r, 0, 0); end
    bitcyc = 4;
    repeat (10) align();
    chk("overflow_set", ledb[3], 1);
    chk("fifo_full_seen", seen_full, 1);
    btn = 4'b0001; align(); btn = 4'b0000;
    @(negedge clk_pad); chk("overflow_clr", ledb[3], 0);
    align();

    // reset mid-stream
    repeat (7) align();
    rst = 1; align(); align();
    @(negedge clk_pad);
    chk("rst2_dout_sout", {d_out, s_out}, 2'b00);
    chk("rst2_led", led, 0);
    chk("rst2_ledb", ledb, 0);
    @(posedge clk_pad); #1 rst = 0;
    @(negedge clk_pad); @(negedge clk_pad);
    chk("rst2_first_bit", {d_out, s_out}, 2'b01);
    repeat (200) align();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
